// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_pkg
// Purpose  : Shared types and constants for the FIFO read-side drain block.
//            Provides the controller state encoding, the upper bound on the
//            supported FIFO read latency, and the buffer-depth helper used to
//            size the local landing buffer.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  localparam int MAX_RD_LATENCY = 4;

  // One slot per word that can be in flight plus one for the word being
  // presented downstream, which is what lets the stream run at 1 word/cycle.
  function automatic int buf_depth(input int rd_latency);
    return rd_latency + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_skid_buf
// Purpose  : Small in-order buffer that catches words arriving from the FIFO
//            read pipeline and presents the oldest one as the stream head.
//            A push and a pop in the same cycle leave the occupancy unchanged.
// Ports    : clk        - clock
//            rst        - synchronous active-high reset, empties the buffer
//            push       - write push_data at the tail this cycle
//            push_data  - word to store
//            pop        - retire the head this cycle
//            occ        - number of stored words
//            head       - oldest stored word
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_skid_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2,
  parameter int OCC_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [OCC_WIDTH-1:0]  occ,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [OCC_WIDTH-1:0]  count;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // When full, a same-cycle push lands in the slot the head is leaving.
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && (count == OCC_WIDTH'(DEPTH))));
      assert (!(pop && (count == '0)));
    end
  end

  assign occ  = count;
  assign head = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fifo_rd_drain.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_drain
// Purpose  : Read-side consumer of an asynchronous FIFO in the rd_clk domain.
//            Pops words while enabled and the FIFO is non-empty, tracks the
//            FIFO's fixed read latency, lands returning words in a local
//            buffer and presents them as a valid/ready stream.
// Ports    : rd_clk     - clock
//            rd_rst     - synchronous active-high reset
//            enable     - request to drain the FIFO
//            empty      - FIFO empty flag
//            fifo_data  - FIFO read data, valid RD_LATENCY cycles after rd_en
//            rd_en      - FIFO pop strobe
//            m_valid    - stream word valid
//            m_data     - stream word
//            m_ready    - downstream accepts the word
//            busy       - active, words in flight or words buffered
//            pop_count  - number of rd_en pulses, wraps modulo 2^CNT_WIDTH
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  enable,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  pop_count
);

  localparam int BUF_DEPTH = buf_depth(RD_LATENCY);
  localparam int OCC_WIDTH = $clog2(BUF_DEPTH + 1);
  localparam int CRD_WIDTH = OCC_WIDTH + 1;

  if ((RD_LATENCY < 1) || (RD_LATENCY > MAX_RD_LATENCY)) begin : g_bad_latency
    $error("fifo_rd_drain: RD_LATENCY out of supported range");
  end

  rd_state_t               state;
  rd_state_t               state_nxt;
  logic [RD_LATENCY-1:0]   flight_pipe;
  logic [OCC_WIDTH-1:0]    inflight;
  logic [OCC_WIDTH-1:0]    occ;
  logic [DATA_WIDTH-1:0]   head;
  logic                    land;
  logic                    pop;
  logic [CRD_WIDTH-1:0]    credit_used;
  logic [CRD_WIDTH-1:0]    credit_limit;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN: begin
        if (enable) begin
          state_nxt = RUN;
        end else if (inflight == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------ latency pipe
  // Bit k set means a pop issued k+1 cycles ago; the top bit marks the
  // cycle in which that word is present on fifo_data.
  if (RD_LATENCY == 1) begin : g_pipe_single
    always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
        flight_pipe <= '0;
      end else begin
        flight_pipe <= rd_en;
      end
    end
  end else begin : g_pipe_shift
    always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
        flight_pipe <= '0;
      end else begin
        flight_pipe <= {flight_pipe[RD_LATENCY-2:0], rd_en};
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + OCC_WIDTH'(flight_pipe[i]);
    end
  end

  assign land = flight_pipe[RD_LATENCY-1];

  // ------------------------------------------------------ credit / pop
  // Every buffered or in-flight word holds a buffer slot; a word leaving
  // downstream this cycle frees its slot in time for a new pop.
  assign credit_used  = CRD_WIDTH'(occ) + CRD_WIDTH'(inflight);
  assign credit_limit = CRD_WIDTH'(BUF_DEPTH) + CRD_WIDTH'(pop);
  assign rd_en        = (state == RUN) && !empty && (credit_used < credit_limit);

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      pop_count <= '0;
    end else if (rd_en) begin
      pop_count <= pop_count + 1'b1;
    end
  end

  // ------------------------------------------------------ landing buffer
  fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH),
    .OCC_WIDTH  (OCC_WIDTH)
  ) u_skid_buf (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .push      (land),
    .push_data (fifo_data),
    .pop       (pop),
    .occ       (occ),
    .head      (head)
  );

  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;
  // Stale slot contents are never shown once the buffer empties.
  assign m_data  = m_valid ? head : '0;
  assign busy    = (state != IDLE) || (inflight != '0) || m_valid;

endmodule
`default_nettype wire
